pauli_z_stream: RTL

PAULI_Z_STREAM -- requirements
Module: pauli_z_stream

---
 rtl/pauli_z_stream.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pauli_z_stream.sv
`timescale 1ns/1ps
// pauli_z_stream: streaming Pauli-Z phase flip over a state-vector frame.
// Amplitudes arrive in basis order; a 2-entry skid buffer decouples ready.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif

module pauli_z_stream #(
    parameter int FIXED_WIDTH = `FIXED_WIDTH,
    parameter int NUM_QUBITS  = 4,
    localparam int TQW = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [TQW-1:0]                target_q,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic signed [FIXED_WIDTH-1:0] s_real,
    input  logic signed [FIXED_WIDTH-1:0] s_imag,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic signed [FIXED_WIDTH-1:0] m_real,
    output logic signed [FIXED_WIDTH-1:0] m_imag,
    output logic                          m_last,
    output logic                          frame_err
);

    localparam logic [NUM_QUBITS-1:0] IDX_MAX = '1;
    localparam logic [TQW:0] NQ = (TQW+1)'(NUM_QUBITS);
    localparam logic signed [FIXED_WIDTH-1:0] MINV = {1'b1, {(FIXED_WIDTH-1){1'b0}}};
    localparam logic signed [FIXED_WIDTH-1:0] MAXV = ~MINV;

    function automatic logic signed [FIXED_WIDTH-1:0] neg_sat(
        input logic signed [FIXED_WIDTH-1:0] x
    );
        if (x == MINV) return MAXV;
        return -x;
    endfunction

    logic [NUM_QUBITS-1:0] idx;
    logic [NUM_QUBITS-1:0] idx_sh;
    logic [TQW-1:0] tq_reg;
    logic [TQW-1:0] cur_tq;
    logic live;
    logic flip;
    logic in_xfer;
    logic out_xfer;

    logic signed [FIXED_WIDTH-1:0] beat_r, beat_i;
    logic beat_l;

    logic out_v, skid_v;
    logic signed [FIXED_WIDTH-1:0] out_r, out_i, skid_r, skid_i;
    logic out_l, skid_l;

    // ready depends only on registered state, never on m_ready
    assign s_ready  = live & ~skid_v;
    assign in_xfer  = s_valid & s_ready;
    assign out_xfer = out_v & m_ready;

    assign m_valid = out_v;
    assign m_real  = out_r;
    assign m_imag  = out_i;
    assign m_last  = out_l;

    // transform the incoming beat; beat 0 uses the live target index
    always_comb begin
        cur_tq = (idx == '0) ? target_q : tq_reg;
        idx_sh = idx >> cur_tq;
        flip   = ({1'b0, cur_tq} < NQ) && idx_sh[0];
        beat_r = flip ? neg_sat(s_real) : s_real;
        beat_i = flip ? neg_sat(s_imag) : s_imag;
        beat_l = (idx == IDX_MAX);
    end

    // frame index, target capture and sticky framing error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            tq_reg    <= '0;
            frame_err <= 1'b0;
            live      <= 1'b0;
        end else begin
            live <= 1'b1;
            if (in_xfer) begin
                idx <= idx + 1'b1;
                if (idx == '0) tq_reg <= target_q;
                if (s_last != beat_l) frame_err <= 1'b1;
            end
        end
    end

    // output register plus skid register, skid always drains first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v  <= 1'b0;
            out_r  <= '0;
            out_i  <= '0;
            out_l  <= 1'b0;
            skid_v <= 1'b0;
            skid_r <= '0;
            skid_i <= '0;
            skid_l <= 1'b0;
        end else begin
            if (!out_v || out_xfer) begin
                if (skid_v) begin
                    out_v  <= 1'b1;
                    out_r  <= skid_r;
                    out_i  <= skid_i;
                    out_l  <= skid_l;
                    skid_v <= 1'b0;
                end else if (in_xfer) begin
                    out_v <= 1'b1;
                    out_r <= beat_r;
                    out_i <= beat_i;
                    out_l <= beat_l;
                end else begin
                    out_v <= 1'b0;
                end
            end else if (in_xfer) begin
                skid_v <= 1'b1;
                skid_r <= beat_r;
                skid_i <= beat_i;
                skid_l <= beat_l;
            end
        end
    end

endmodule
